// File: rtl/core_cmd_feeder.sv
// Command/byte feeder for the image-processing core: queues host op-modes and load bytes, then
// replays them on the core's op/in handshakes. Optional stall counter: define FEEDER_STALL_CNT_EN.
module core_cmd_feeder #(
  parameter int CMD_DEPTH  = 8,
  parameter int DAT_DEPTH  = 16,
  parameter int LOAD_BYTES = 2048
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cmd_valid,
  input  logic [3:0] i_cmd_mode,
  output logic       o_cmd_ready,
  input  logic       i_dat_valid,
  input  logic [7:0] i_dat,
  output logic       o_dat_ready,
  input  logic       i_op_ready,
  output logic       o_op_valid,
  output logic [3:0] o_op_mode,
  output logic       o_in_valid,
  output logic [7:0] o_in_data,
  input  logic       i_in_ready,
  output logic       o_busy,
  output logic       o_proto_err
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [31:0] o_stall_cnt
`endif
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_LOAD} state_t;

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int DAW = $clog2(DAT_DEPTH);
  localparam logic [11:0] LOAD_LAST = 12'(LOAD_BYTES - 1);

  state_t       state, state_nxt;
  logic         rdy_pend;
  logic [11:0]  byte_cnt;

  logic [3:0]   cmd_mem [CMD_DEPTH];
  logic [CAW:0] cmd_wr, cmd_rd;
  logic [7:0]   dat_mem [DAT_DEPTH];
  logic [DAW:0] dat_wr, dat_rd;

  logic cmd_full, cmd_empty, dat_full, dat_empty;
  logic cmd_push, cmd_pop, dat_push, dat_pop;
  logic xfer, last_xfer, stage_load, op_err;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign cmd_full  = (cmd_wr[CAW] != cmd_rd[CAW]) && (cmd_wr[CAW-1:0] == cmd_rd[CAW-1:0]);
  assign cmd_empty = (cmd_wr == cmd_rd);
  assign dat_full  = (dat_wr[DAW] != dat_rd[DAW]) && (dat_wr[DAW-1:0] == dat_rd[DAW-1:0]);
  assign dat_empty = (dat_wr == dat_rd);

  assign o_cmd_ready = !cmd_full;
  assign o_dat_ready = !dat_full;
  assign cmd_push    = i_cmd_valid && !cmd_full;
  assign dat_push    = i_dat_valid && !dat_full;

  assign xfer      = o_in_valid && i_in_ready;
  assign last_xfer = xfer && (byte_cnt == LOAD_LAST);
  assign op_err    = i_op_ready && ((state != ST_IDLE) || rdy_pend);
  assign dat_pop   = stage_load && !dat_empty;

  assign o_op_valid = (state == ST_ISSUE);
  assign o_busy     = (state != ST_IDLE) || rdy_pend;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_nxt  = state;
    cmd_pop    = 1'b0;
    stage_load = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (rdy_pend && !cmd_empty) begin
          cmd_pop   = 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = (o_op_mode == 4'd0) ? ST_LOAD : ST_IDLE;
      ST_LOAD: begin
        // Refilling only while a byte is still owed means nothing is fetched past the last one.
        if (last_xfer) state_nxt = ST_IDLE;
        else           stage_load = !o_in_valid || xfer;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= ST_IDLE;
      rdy_pend    <= 1'b0;
      byte_cnt    <= '0;
      o_op_mode   <= '0;
      o_in_valid  <= 1'b0;
      o_in_data   <= '0;
      o_proto_err <= 1'b0;
      cmd_wr      <= '0;
      cmd_rd      <= '0;
      dat_wr      <= '0;
      dat_rd      <= '0;
    end else begin
      state <= state_nxt;

      if (cmd_push) cmd_wr <= cmd_wr + (CAW+1)'(1);
      if (cmd_pop)  cmd_rd <= cmd_rd + (CAW+1)'(1);
      if (dat_push) dat_wr <= dat_wr + (DAW+1)'(1);
      if (dat_pop)  dat_rd <= dat_rd + (DAW+1)'(1);

      if (cmd_pop) begin
        rdy_pend  <= 1'b0;
        o_op_mode <= cmd_mem[cmd_rd[CAW-1:0]];
      end else if (i_op_ready && (state == ST_IDLE)) begin
        rdy_pend <= 1'b1;
      end

      if (op_err) o_proto_err <= 1'b1;

      if (last_xfer) begin
        o_in_valid <= 1'b0;
        byte_cnt   <= '0;
      end else begin
        if (xfer)       byte_cnt   <= byte_cnt + 12'd1;
        if (stage_load) o_in_valid <= !dat_empty;
        if (dat_pop)    o_in_data  <= dat_mem[dat_rd[DAW-1:0]];
      end
    end
  end

  // NOTE: FIFO storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (cmd_push) cmd_mem[cmd_wr[CAW-1:0]] <= i_cmd_mode;
    if (dat_push) dat_mem[dat_wr[DAW-1:0]] <= i_dat;
  end

`ifdef FEEDER_STALL_CNT_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_stall_cnt <= '0;
    else if (o_in_valid && !i_in_ready && (o_stall_cnt != '1))
      o_stall_cnt <= o_stall_cnt + 32'd1;
  end
`endif

endmodule
